// File: rtl/spinner_pkg.sv
// Shared types and constants for the multi-channel rotary-control emulator.
package spinner_pkg;

    // Rotation direction requested by the buttons on a strobe edge
    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } spin_dir_t;

    // Width of one channel's signed mouse delta
    localparam int MOUSE_W = 9;

    // Exactly one button pressed selects a direction; none or both means idle
    function automatic spin_dir_t decode_dir(input logic plus, input logic minus);
        spin_dir_t dir;
        dir = DIR_IDLE;
        if (plus && !minus) begin
            dir = DIR_CW;
        end else if (minus && !plus) begin
            dir = DIR_CCW;
        end
        return dir;
    endfunction

endpackage

// File: rtl/spinner_multi_if.sv
// Input-mapping side bundle for spinner_multi: buttons, mouse deltas and angle outputs.
interface spinner_multi_if
    import spinner_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ANGLE_W  = 4
);
    logic                          strobe;
    logic [CHANNELS-1:0]           minus;
    logic [CHANNELS-1:0]           plus;
    logic [CHANNELS-1:0]           fast;
    logic [CHANNELS-1:0]           mouse_en;
    logic [CHANNELS-1:0]           mouse_strobe;
    logic [MOUSE_W*CHANNELS-1:0]   mouse_dx;
    logic [ANGLE_W*CHANNELS-1:0]   spin_angle;
    logic [CHANNELS-1:0]           spin_changed;

    // Input mapping drives controls and reads angles back
    modport master (
        output strobe, minus, plus, fast, mouse_en, mouse_strobe, mouse_dx,
        input  spin_angle, spin_changed
    );

    // The spinner consumes controls and produces angles
    modport slave (
        input  strobe, minus, plus, fast, mouse_en, mouse_strobe, mouse_dx,
        output spin_angle, spin_changed
    );

endinterface

// File: rtl/spinner_chan.sv
// One spinner channel: direction tracking, hold acceleration and the wrapped
// fractional angle accumulator fed by buttons and mouse deltas.
module spinner_chan
    import spinner_pkg::*;
#(
    parameter int ANGLE_W      = 4,
    parameter int FRAC_W       = 4,
    parameter int STEP_SLOW    = 4,
    parameter int STEP_FAST    = 16,
    parameter int ACCEL_FRAMES = 8,
    parameter int ACCEL_MAX    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               strobe_edge,
    input  logic               plus,
    input  logic               minus,
    input  logic               fast,
    input  logic               mouse_en,
    input  logic               mouse_strobe,
    input  logic [MOUSE_W-1:0] mouse_dx,
    output logic [ANGLE_W-1:0] spin_angle,
    output logic               spin_changed
);

    localparam int ACC_W  = ANGLE_W + FRAC_W;
    localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);
    localparam int LVL_W  = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;

    localparam logic [LVL_W-1:0]  LVL_TOP    = LVL_W'(ACCEL_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ACCEL_FRAMES - 1);
    localparam logic [ACC_W-1:0]  BASE_SLOW  = ACC_W'(STEP_SLOW);
    localparam logic [ACC_W-1:0]  BASE_FAST  = ACC_W'(STEP_FAST);

    spin_dir_t          prev_dir_q, prev_dir_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               changed_q, changed_d;

    spin_dir_t          dir;
    logic [LVL_W-1:0]   use_lvl;
    logic [ACC_W-1:0]   step;
    logic [ACC_W-1:0]   delta_b;
    logic [ACC_W-1:0]   delta_m;
    logic [ACC_W-1:0]   delta_sum;

    // Next-state logic: acceleration bookkeeping on strobe edges, then sum both delta sources
    always_comb begin
        dir        = decode_dir(plus, minus);
        prev_dir_d = prev_dir_q;
        hold_cnt_d = hold_cnt_q;
        lvl_d      = lvl_q;
        use_lvl    = '0;

        if (strobe_edge) begin
            if (dir == DIR_IDLE) begin
                prev_dir_d = DIR_IDLE;
                hold_cnt_d = '0;
                lvl_d      = '0;
            end else if (dir != prev_dir_q) begin
                // A new or reversed direction always restarts from the base step
                prev_dir_d = dir;
                hold_cnt_d = HOLD_W'(1);
                lvl_d      = '0;
            end else begin
                use_lvl = lvl_q;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    lvl_d      = (lvl_q == LVL_TOP) ? lvl_q : lvl_q + LVL_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
        end

        step = (fast ? BASE_FAST : BASE_SLOW) << use_lvl;

        delta_b = '0;
        if (strobe_edge && (dir == DIR_CW)) begin
            delta_b = step;
        end else if (strobe_edge && (dir == DIR_CCW)) begin
            delta_b = (~step) + ACC_W'(1);
        end

        delta_m = '0;
        if (mouse_strobe && mouse_en) begin
            delta_m = ACC_W'($signed(mouse_dx));
        end

        delta_sum = delta_b + delta_m;
        acc_d     = acc_q + delta_sum;
        changed_d = |delta_sum;
    end

    // State registers; reset discards anything computed in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_dir_q <= DIR_IDLE;
            hold_cnt_q <= '0;
            lvl_q      <= '0;
            acc_q      <= '0;
            changed_q  <= 1'b0;
        end else begin
            prev_dir_q <= prev_dir_d;
            hold_cnt_q <= hold_cnt_d;
            lvl_q      <= lvl_d;
            acc_q      <= acc_d;
            changed_q  <= changed_d;
        end
    end

    assign spin_angle   = acc_q[ACC_W-1:FRAC_W];
    assign spin_changed = changed_q;

endmodule

// File: rtl/spinner_multi.sv
// Multi-channel rotary-control emulator: one shared frame-strobe edge detector
// driving an independent spinner channel per player.
module spinner_multi
    import spinner_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int ANGLE_W      = 4,
    parameter int FRAC_W       = 4,
    parameter int STEP_SLOW    = 4,
    parameter int STEP_FAST    = 16,
    parameter int ACCEL_FRAMES = 8,
    parameter int ACCEL_MAX    = 2
) (
    input  logic          clk,
    input  logic          reset,
    spinner_multi_if.slave bus
);

    logic strobe_prev_q, strobe_prev_d;
    logic strobe_edge;

    // Track the previous strobe level so a rising edge is seen exactly once
    always_comb begin
        strobe_prev_d = bus.strobe;
        strobe_edge   = bus.strobe & ~strobe_prev_q;
    end

    // Strobe history register
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_prev_q <= 1'b0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        spinner_chan #(
            .ANGLE_W      (ANGLE_W),
            .FRAC_W       (FRAC_W),
            .STEP_SLOW    (STEP_SLOW),
            .STEP_FAST    (STEP_FAST),
            .ACCEL_FRAMES (ACCEL_FRAMES),
            .ACCEL_MAX    (ACCEL_MAX)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .strobe_edge  (strobe_edge),
            .plus         (bus.plus[g]),
            .minus        (bus.minus[g]),
            .fast         (bus.fast[g]),
            .mouse_en     (bus.mouse_en[g]),
            .mouse_strobe (bus.mouse_strobe[g]),
            .mouse_dx     (bus.mouse_dx[MOUSE_W*g +: MOUSE_W]),
            .spin_angle   (bus.spin_angle[ANGLE_W*g +: ANGLE_W]),
            .spin_changed (bus.spin_changed[g])
        );
    end

endmodule

// File: tb/tb_spinner_multi.sv
// Table-driven bench for spinner_multi with a per-cycle scoreboard backed by a
// behavioural reference model of both channels.
module tb_spinner_multi;
    import spinner_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spinner_multi_if #(.CHANNELS(2), .ANGLE_W(4)) bus ();

    spinner_multi #(
        .CHANNELS(2), .ANGLE_W(4), .FRAC_W(4), .STEP_SLOW(4),
        .STEP_FAST(16), .ACCEL_FRAMES(8), .ACCEL_MAX(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] angles;
        logic [1:0] changed;
    } exp_t;

    typedef struct {
        string      name;
        bit         do_reset;
        int         edges;
        logic [1:0] plus;
        logic [1:0] minus;
        logic [1:0] fast;
        logic [1:0] men;
        logic [1:0] mstb;
        logic [8:0] dx0;
        logic [8:0] dx1;
        int         exp_ang0;
        int         exp_ang1;
        int         exp_pulse0;
        int         exp_pulse1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;
    int   pulse_cnt [2];

    int   m_acc  [2];
    int   m_prev [2];
    int   m_hold [2];
    int   m_lvl  [2];
    bit   m_stb_d;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model: advance one clock and queue the outputs expected after it
    task automatic modelCycle(input bit rst, input bit stb, input logic [1:0] p, input logic [1:0] m,
                              input logic [1:0] f, input logic [1:0] me, input logic [1:0] ms,
                              input logic [8:0] dx0, input logic [8:0] dx1);
        exp_t       e;
        bit         edge_seen;
        int         dir, use_lvl, step, delta;
        logic [8:0] dx;
        e = '0;
        edge_seen = stb && !m_stb_d;
        m_stb_d = rst ? 1'b0 : stb;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_acc[c] = 0; m_prev[c] = 0; m_hold[c] = 0; m_lvl[c] = 0;
            end else begin
                delta = 0;
                dir = (p[c] && !m[c]) ? 1 : ((m[c] && !p[c]) ? 2 : 0);
                if (edge_seen) begin
                    if (dir == 0) begin
                        m_prev[c] = 0; m_hold[c] = 0; m_lvl[c] = 0;
                    end else begin
                        use_lvl = (dir == m_prev[c]) ? m_lvl[c] : 0;
                        step = ((f[c] ? 16 : 4) * (1 << use_lvl)) % 256;
                        delta = (dir == 1) ? step : -step;
                        if (dir != m_prev[c]) begin
                            m_prev[c] = dir; m_hold[c] = 1; m_lvl[c] = 0;
                        end else if (m_hold[c] + 1 == 8) begin
                            m_hold[c] = 0;
                            m_lvl[c] = (m_lvl[c] < 2) ? m_lvl[c] + 1 : 2;
                        end else begin
                            m_hold[c] = m_hold[c] + 1;
                        end
                    end
                end
                if (ms[c] && me[c]) begin
                    dx = (c == 0) ? dx0 : dx1;
                    delta = delta + int'($signed(dx));
                end
                delta = ((delta % 256) + 256) % 256;
                m_acc[c] = (m_acc[c] + delta) % 256;
                e.changed[c] = (delta != 0);
            end
            e.angles[c*4 +: 4] = 4'(m_acc[c] / 16);
        end
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check("angle0",   int'(bus.spin_angle[3:0]), int'(e.angles[3:0]));
        check("angle1",   int'(bus.spin_angle[7:4]), int'(e.angles[7:4]));
        check("changed0", int'(bus.spin_changed[0]), int'(e.changed[0]));
        check("changed1", int'(bus.spin_changed[1]), int'(e.changed[1]));
        for (int c = 0; c < 2; c++) pulse_cnt[c] += int'(bus.spin_changed[c]);
    endtask

    task automatic applyStimulus(input bit rst, input bit stb, input logic [1:0] p, input logic [1:0] m,
                                 input logic [1:0] f, input logic [1:0] me, input logic [1:0] ms,
                                 input logic [8:0] dx0, input logic [8:0] dx1);
        @(negedge clk);
        reset            = rst;
        bus.strobe       = stb;
        bus.plus         = p;
        bus.minus        = m;
        bus.fast         = f;
        bus.mouse_en     = me;
        bus.mouse_strobe = ms;
        bus.mouse_dx     = {dx1, dx0};
        modelCycle(rst, stb, p, m, f, me, ms, dx0, dx1);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One strobe rising edge (mouse pulse optionally aligned with it), then strobe low
    task automatic doEdge(input logic [1:0] p, input logic [1:0] m, input logic [1:0] f,
                          input logic [1:0] me, input logic [1:0] ms,
                          input logic [8:0] dx0, input logic [8:0] dx1);
        applyStimulus(1'b0, 1'b1, p, m, f, me, ms, dx0, dx1);
        applyStimulus(1'b0, 1'b0, p, m, f, me, 2'b00, dx0, dx1);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0);
    endtask

    function automatic vec_t mkvec(input string n, input bit r, input int ed,
                                   input logic [1:0] p, input logic [1:0] m, input logic [1:0] f,
                                   input logic [1:0] me, input logic [1:0] ms,
                                   input logic [8:0] dx0, input logic [8:0] dx1,
                                   input int a0, input int a1, input int p0, input int p1);
        vec_t v;
        v.name = n; v.do_reset = r; v.edges = ed;
        v.plus = p; v.minus = m; v.fast = f; v.men = me; v.mstb = ms;
        v.dx0 = dx0; v.dx1 = dx1;
        v.exp_ang0 = a0; v.exp_ang1 = a1; v.exp_pulse0 = p0; v.exp_pulse1 = p1;
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        bus.strobe = 1'b0; bus.plus = '0; bus.minus = '0; bus.fast = '0;
        bus.mouse_en = '0; bus.mouse_strobe = '0; bus.mouse_dx = '0;
        m_stb_d = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_prev[c] = 0; m_hold[c] = 0; m_lvl[c] = 0; pulse_cnt[c] = 0;
        end

        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("slow_cw_x4",     0, 4,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     1,  0, 4, 0));
        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("hold_to_8",      0, 8,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     2,  0, 8, 0));
        vecs.push_back(mkvec("hold_to_16",     0, 8,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     6,  0, 8, 0));
        vecs.push_back(mkvec("hold_to_24",     0, 8,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     14, 0, 8, 0));
        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("ccw_wrap",       0, 1,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     15, 0, 1, 0));
        vecs.push_back(mkvec("both_idle",      0, 3,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     15, 0, 0, 0));
        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("mouse_and_edge", 0, 1,  2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 9'd0, 9'h1EC,   0, 15, 0, 1));
        vecs.push_back(mkvec("mouse_dropped",  0, 1,  2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 9'd0, 9'h1EC,   0, 15, 0, 1));
        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("fast_cw",        0, 1,  2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 9'd0, 9'd0,     1,  0, 1, 0));
        vecs.push_back(mkvec("fast_flip_ccw",  0, 1,  2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 1, 0));
        vecs.push_back(mkvec("reset",          1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0,     0,  0, 0, 0));
        vecs.push_back(mkvec("independent",    0, 2,  2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 9'd0, 9'd0,     0, 14, 2, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            pulse_cnt[0] = 0;
            pulse_cnt[1] = 0;
            if (vecs[i].do_reset) begin
                doReset();
            end else begin
                for (int k = 0; k < vecs[i].edges; k++) begin
                    doEdge(vecs[i].plus, vecs[i].minus, vecs[i].fast, vecs[i].men,
                           vecs[i].mstb, vecs[i].dx0, vecs[i].dx1);
                end
            end
            check({vecs[i].name, "_ang0"},   int'(bus.spin_angle[3:0]), vecs[i].exp_ang0);
            check({vecs[i].name, "_ang1"},   int'(bus.spin_angle[7:4]), vecs[i].exp_ang1);
            check({vecs[i].name, "_pulse0"}, pulse_cnt[0], vecs[i].exp_pulse0);
            check({vecs[i].name, "_pulse1"}, pulse_cnt[1], vecs[i].exp_pulse1);
        end

        // Reset asserted mid-rotation, coinciding with a strobe edge and mouse pulses
        doReset();
        for (int k = 0; k < 16; k++) doEdge(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0);
        check("pre_reset_ang0", int'(bus.spin_angle[3:0]), 6);
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 9'd5, 9'd5);
        check("mid_reset_angles",  int'(bus.spin_angle), 0);
        check("mid_reset_changed", int'(bus.spin_changed), 0);
        pulse_cnt[0] = 0;
        for (int k = 0; k < 4; k++) doEdge(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0);
        check("post_reset_lvl0_ang0", int'(bus.spin_angle[3:0]), 1);
        check("post_reset_pulse0",    pulse_cnt[0], 4);

        // Button and mouse cancelling in the same cycle: no change pulse
        doReset();
        pulse_cnt[0] = 0;
        doEdge(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 9'h1FC, 9'd0);
        check("cancel_ang0",   int'(bus.spin_angle[3:0]), 0);
        check("cancel_pulse0", pulse_cnt[0], 0);

        // Mouse-only wrap through zero, then a full-turn delta that nets nothing
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 9'd0, 9'h1FF);
        check("mouse_neg1_ang1", int'(bus.spin_angle[7:4]), 15);
        check("mouse_neg1_chg1", int'(bus.spin_changed[1]), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 9'd0, 9'h0FF);
        check("mouse_pos255_ang1", int'(bus.spin_angle[7:4]), 15);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 9'd0, 9'h100);
        check("mouse_neg256_chg1", int'(bus.spin_changed[1]), 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 9'd0, 9'h010);
        check("mouse_disabled_chg1", int'(bus.spin_changed[1]), 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 9'd0, 9'd0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
